// File: rtl/encoder_round_scheduler_pkg.sv
// Shared definitions for the encoder round scheduler: FSM encoding,
// step-engine order and default loop bounds.
package encoder_round_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_DONE    = 3'd5
  } sched_state_t;

  // Execution order of the step engines within one round
  localparam logic [2:0] STEP_COLPARITY = 3'd0;
  localparam logic [2:0] STEP_ROTATE    = 3'd1;
  localparam logic [2:0] STEP_PERMUTE   = 3'd2;
  localparam logic [2:0] STEP_REVALUATE = 3'd3;
  localparam logic [2:0] STEP_ADDRC     = 3'd4;

  localparam int NUM_STEPS_DEF  = 5;
  localparam int NUM_ROUNDS_DEF = 24;

endpackage

// File: rtl/encoder_round_scheduler_sched_counter.sv
// Mod-N counter with synchronous clear-to-zero, enable and terminal-count flag.
module sched_counter #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_init0,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_co
);

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] r_count;

  // Count register: clear has priority over increment, wraps after N-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {W{1'b0}};
    end else if (i_init0) begin
      r_count <= {W{1'b0}};
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? {W{1'b0}} : r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_co    = (r_count == LAST);

endmodule

// File: rtl/encoder_round_scheduler.sv
// Round/step sequencer for the encoder permutation: launches each step engine
// in order, waits for its done pulse, and flips the ping-pong state memory.
module encoder_round_scheduler
  import encoder_round_scheduler_pkg::*;
#(
  parameter int NUM_STEPS  = NUM_STEPS_DEF,
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int SW         = 3,
  parameter int RW         = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [NUM_STEPS-1:0] i_step_ready,
  output logic [NUM_STEPS-1:0] o_step_start,
  output logic [RW-1:0]        o_round,
  output logic [SW-1:0]        o_step_idx,
  output logic                 o_buf_sel,
  output logic                 o_busy,
  output logic                 o_ready
);

  localparam logic [NUM_STEPS-1:0] FIRST_VEC = NUM_STEPS'(1);

  sched_state_t         r_state;
  logic [NUM_STEPS-1:0] r_step_start;
  logic                 r_busy;
  logic                 r_ready;
  logic                 r_buf_sel;

  logic [SW-1:0] w_step_idx;
  logic [SW-1:0] w_step_next;
  logic [RW-1:0] w_round;
  logic          w_step_co;
  logic          w_round_co;
  logic          w_arm;
  logic          w_adv;
  logic          w_round_en;

  assign w_arm       = (r_state == ST_ARM);
  assign w_adv       = (r_state == ST_ADVANCE);
  assign w_round_en  = w_adv & w_step_co & ~w_round_co;
  assign w_step_next = w_step_co ? {SW{1'b0}} : w_step_idx + SW'(1);

  sched_counter #(.N(NUM_STEPS), .W(SW)) u_step_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_init0 (w_arm),
    .i_en    (w_adv),
    .o_count (w_step_idx),
    .o_co    (w_step_co)
  );

  // Round holds at its terminal value so it still reads NUM_ROUNDS-1 at ready
  sched_counter #(.N(NUM_ROUNDS), .W(RW)) u_round_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_init0 (w_arm),
    .i_en    (w_round_en),
    .o_count (w_round),
    .o_co    (w_round_co)
  );

  // Controller: state plus registered Moore outputs for the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_step_start <= {NUM_STEPS{1'b0}};
      r_busy       <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_step_start <= {NUM_STEPS{1'b0}};
          r_ready      <= 1'b0;
          if (i_start) begin
            r_state <= ST_ARM;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_ARM: begin
          if (i_start) begin
            r_state <= ST_ARM;
          end else begin
            r_state      <= ST_LAUNCH;
            r_step_start <= FIRST_VEC;
          end
        end
        ST_LAUNCH: begin
          r_state      <= ST_WAIT;
          r_step_start <= {NUM_STEPS{1'b0}};
        end
        ST_WAIT: begin
          if (i_step_ready[w_step_idx]) begin
            r_state <= ST_ADVANCE;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_ADVANCE: begin
          if (w_step_co && w_round_co) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
          end else begin
            r_state      <= ST_LAUNCH;
            r_step_start <= FIRST_VEC << w_step_next;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_step_start <= {NUM_STEPS{1'b0}};
          r_busy       <= 1'b0;
          r_ready      <= 1'b0;
        end
      endcase
    end
  end

  // Ping-pong select: flips once per completed step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_sel <= 1'b0;
    end else if (w_arm) begin
      r_buf_sel <= 1'b0;
    end else if (w_adv) begin
      r_buf_sel <= ~r_buf_sel;
    end else begin
      r_buf_sel <= r_buf_sel;
    end
  end

  assign o_step_start = r_step_start;
  assign o_round      = w_round;
  assign o_step_idx   = w_step_idx;
  assign o_buf_sel    = r_buf_sel;
  assign o_busy       = r_busy;
  assign o_ready      = r_ready;

endmodule
